// File: rtl/hs_ram_arbiter.sv
// Shares the game work RAM port between the Z80 bus and the hiscore engine; grant lands SETTLE cycles after the idle-sample edge.
// Optional HS_ARB_TIMEOUT_EN: PAUSING watchdog forces SETTLE after TIMEOUT cycles and sets sticky arb_err.
module hs_ram_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_ce,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_pause,
  output logic          cpu_pause,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  input  logic          hs_wr,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          arb_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAUSING = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       bus_idle;
  logic       wd_fire;
  logic       cpu_owns;
  logic       pause_int;

  assign bus_idle = cpu_ce & ~cpu_rd & ~cpu_wr;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  assign wd_fire = (state == ST_PAUSING) && (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      if (state == ST_PAUSING) wd_cnt <= wd_cnt + 1'b1;
      else                     wd_cnt <= '0;
      // Only a watchdog-forced exit counts as an error, not an abort by hs_req.
      if (wd_fire && hs_req && !bus_idle) arb_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign wd_fire        = 1'b0;
  assign arb_err        = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                settle_cnt <= '0;
    else if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
    else                         settle_cnt <= '0;
  end

  // A dropped hs_req always wins, including on the cycle SETTLE would complete.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (hs_req) state_nxt = ST_PAUSING;
      end
      ST_PAUSING: begin
        if (!hs_req)                 state_nxt = ST_RELEASE;
        else if (bus_idle || wd_fire) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!hs_req)                             state_nxt = ST_RELEASE;
        else if (settle_cnt == 4'(SETTLE - 1)) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (!hs_req) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hs_gnt    = (state == ST_GRANT);
    cpu_owns  = (state == ST_IDLE);
    pause_int = (state != ST_IDLE);
  end

  assign cpu_pause = ext_pause | pause_int;
  assign ram_addr  = hs_gnt ? hs_addr  : cpu_addr;
  assign ram_wdata = hs_gnt ? hs_wdata : cpu_wdata;
  assign ram_we    = hs_gnt ? hs_wr    : (cpu_wr & cpu_ce & cpu_owns);
  assign cpu_rdata = ram_rdata;
  assign hs_rdata  = ram_rdata;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter with a synchronous 1-cycle RAM model.
module tb_hs_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk_sys;
  logic          reset_n;
  logic          cpu_ce;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [DW-1:0] cpu_rdata;
  logic          ext_pause;
  logic          cpu_pause;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wdata;
  logic          hs_wr;
  logic [DW-1:0] hs_rdata;
  logic          hs_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          arb_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(2), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
    .ext_pause(ext_pause), .cpu_pause(cpu_pause),
    .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_wr(hs_wr), .hs_rdata(hs_rdata), .hs_gnt(hs_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .arb_err(arb_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    logic gnt_seen;
    logic err_seen;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    reset_n = 1'b0; cpu_ce = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wr = 1'b0; cpu_rd = 1'b0; ext_pause = 1'b0; hs_req = 1'b0;
    hs_addr = '0; hs_wdata = '0; hs_wr = 1'b0;

    // Reset state
    #2;
    check("rst_gnt", hs_gnt, 0);
    check("rst_err", arb_err, 0);
    check("rst_pause", cpu_pause, 0);
    ext_pause = 1'b1; #1;
    check("rst_ext_pause", cpu_pause, 1);
    ext_pause = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // ext_pause passes through without touching arbitration
    ext_pause = 1'b1;
    tick();
    check("ext_pause_on", cpu_pause, 1);
    check("ext_pause_gnt", hs_gnt, 0);
    ext_pause = 1'b0;
    tick();
    check("ext_pause_off", cpu_pause, 0);

    // Basic grant: cpu_ce every 4th cycle, first at cycle 3
    cpu_addr = 16'h1234;
    hs_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cpu_ce = (c % 4 == 3);
      check("t2_pause", cpu_pause, 1);
      check($sformatf("t2_gnt_c%0d", c), hs_gnt, (c == 6));
    end
    hs_wr = 1'b1; hs_addr = 16'h6010; hs_wdata = 8'hA5;
    #1;
    check("t2_we", ram_we, 1);
    check("t2_addr", ram_addr, 16'h6010);
    check("t2_wdata", ram_wdata, 8'hA5);
    tick();
    hs_wr = 1'b0;

    // Write blocking: CPU write during GRANT is dropped
    cpu_wr = 1'b1; cpu_ce = 1'b1; cpu_addr = 16'h6010; cpu_wdata = 8'h5A;
    #1;
    check("t5_we", ram_we, 0);
    tick();
    check("t5_hs_rdata", hs_rdata, 8'hA5);
    hs_req = 1'b0;
    tick();
    check("rel_gnt", hs_gnt, 0);
    check("rel_pause", cpu_pause, 1);
    check("rel_we_blocked", ram_we, 0);
    tick();
    check("idle_pause", cpu_pause, 0);
    check("idle_cpu_we", ram_we, 1);
    cpu_wr = 1'b0; cpu_ce = 1'b0;

    // Abort during SETTLE
    cpu_ce = 1'b1;
    hs_req = 1'b1;
    tick();
    check("t4_pausing_pause", cpu_pause, 1);
    check("t4_pausing_gnt", hs_gnt, 0);
    tick();
    check("t4_settle_gnt", hs_gnt, 0);
    hs_req = 1'b0;
    tick();
    check("t4_rel_gnt", hs_gnt, 0);
    check("t4_rel_pause", cpu_pause, 1);
    tick();
    check("t4_idle_pause", cpu_pause, 0);
    check("t4_idle_gnt", hs_gnt, 0);
    cpu_ce = 1'b0;

    // Busy CPU: reads held over three cpu_ce samples, idle sample at cycle 15
    mem[16'h0042] = 8'h3C;
    cpu_rd = 1'b1; cpu_addr = 16'h0042;
    hs_req = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      cpu_ce = (c % 4 == 3);
      cpu_rd = (c < 15);
      check($sformatf("t3_gnt_c%0d", c), hs_gnt, (c == 18));
      if (c == 4) check("t3_cpu_rdata", cpu_rdata, 8'h3C);
    end

    // Reset during GRANT returns the port asynchronously
    hs_addr = 16'h7777; cpu_addr = 16'h6010;
    #1;
    check("t1_pre_addr", ram_addr, 16'h7777);
    #1;
    reset_n = 1'b0;
    #1;
    check("t1_gnt", hs_gnt, 0);
    check("t1_pause", cpu_pause, 0);
    check("t1_addr", ram_addr, 16'h6010);
    tick();
    reset_n = 1'b1;
    tick();
    check("t1_repause", cpu_pause, 1);
    check("t1_no_gnt0", hs_gnt, 0);
    cpu_ce = 1'b1;
    tick();
    cpu_ce = 1'b0;
    check("t1_no_gnt1", hs_gnt, 0);
    tick();
    check("t1_no_gnt2", hs_gnt, 0);
    tick();
    check("t1_regnt", hs_gnt, 1);
    hs_req = 1'b0;
    tick(); tick();
    check("t1_idle_pause", cpu_pause, 0);

    // Watchdog with the CPU bus held busy
    cpu_ce = 1'b1; cpu_rd = 1'b1;
    hs_req = 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 19; c++) begin
      tick();
      check($sformatf("t6_err_c%0d", c), arb_err, (c >= 17));
      check($sformatf("t6_gnt_c%0d", c), hs_gnt, (c == 19));
    end
    hs_req = 1'b0;
    tick(); tick();
    check("t6_err_sticky", arb_err, 1);
    check("t6_idle_pause", cpu_pause, 0);
`else
    gnt_seen = 1'b0;
    err_seen = 1'b0;
    for (int c = 1; c <= 10000; c++) begin
      tick();
      if (hs_gnt) gnt_seen = 1'b1;
      if (arb_err) err_seen = 1'b1;
    end
    check("t6_no_gnt", gnt_seen, 0);
    check("t6_no_err", err_seen, 0);
    check("t6_still_paused", cpu_pause, 1);
    hs_req = 1'b0;
    tick(); tick();
    check("t6_idle_pause", cpu_pause, 0);
`endif
    cpu_ce = 1'b0; cpu_rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
